// File: rtl/display_controller_line_buffer_pkg.sv
// Shared TileLink-UL types for the display line buffer.
// Holds the A/D channel opcodes and beat structs, the channel widths they are
// built with, and a helper that returns the number of beats a transfer needs.
package display_controller_line_buffer_pkg;

  localparam int TlDataWidth   = 64;
  localparam int TlAddrWidth   = 64;
  localparam int TlSourceWidth = 1;
  localparam int TlSizeWidth   = 3;
  localparam int TlMaskWidth   = TlDataWidth / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    ArithmeticData = 3'd2,
    LogicalData    = 3'd3,
    Get            = 3'd4,
    Intent         = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  typedef struct packed {
    tl_a_op_e                 opcode;
    logic [2:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic [TlAddrWidth-1:0]   address;
    logic [TlMaskWidth-1:0]   mask;
    logic                     corrupt;
    logic [TlDataWidth-1:0]   data;
  } tl_a_t;

  typedef struct packed {
    tl_d_op_e                 opcode;
    logic [1:0]               param;
    logic [TlSizeWidth-1:0]   size;
    logic [TlSourceWidth-1:0] source;
    logic                     sink;
    logic                     denied;
    logic                     corrupt;
    logic [TlDataWidth-1:0]   data;
  } tl_d_t;

  // Beats for a transfer of 2^size bytes on a bus of 2^nbs bytes.
  function automatic int unsigned tl_beats(input int unsigned size, input int unsigned nbs);
    return (size <= nbs) ? 32'd1 : (32'd1 << (size - nbs));
  endfunction

endpackage

// File: rtl/display_controller_line_ram.sv
// Depth x DataWidth line RAM.
// Port A: synchronous read/write with byte enables (TL side), read-first.
// Port B: synchronous read only (scanout side). Read data registers reset to 0
// and hold their value while the port is not enabled; the array is not reset.
//  i_clk, i_rst_n          clock, async active-low reset (read registers only)
//  i_a_en/i_a_we/i_a_be    port A enable, write enable, byte enables
//  i_a_addr/i_a_wdata      port A word address, write data
//  o_a_rdata               port A read data (1 cycle after i_a_en)
//  i_b_en/i_b_addr         port B enable, word address
//  o_b_rdata               port B read data (1 cycle after i_b_en)
module display_controller_line_ram #(
  parameter int DataWidth = 64,
  parameter int Depth     = 512,
  localparam int Aw       = $clog2(Depth),
  localparam int Bw       = DataWidth / 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_a_en,
  input  logic                 i_a_we,
  input  logic [Bw-1:0]        i_a_be,
  input  logic [Aw-1:0]        i_a_addr,
  input  logic [DataWidth-1:0] i_a_wdata,
  output logic [DataWidth-1:0] o_a_rdata,
  input  logic                 i_b_en,
  input  logic [Aw-1:0]        i_b_addr,
  output logic [DataWidth-1:0] o_b_rdata
);

  logic [DataWidth-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_a_en && i_a_we) begin
      for (int b = 0; b < Bw; b++) begin
        if (i_a_be[b]) r_mem[i_a_addr][b*8 +: 8] <= i_a_wdata[b*8 +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands: old data on collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_a_rdata <= '0;
    else if (i_a_en) o_a_rdata <= r_mem[i_a_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    o_b_rdata <= '0;
    else if (i_b_en) o_b_rdata <= r_mem[i_b_addr];
  end

endmodule

// File: rtl/display_controller_line_buffer.sv
// TileLink-UL responder for the display line buffer.
// Accepts Put bursts from the display DMA and Get bursts for readback, one
// transaction at a time, and stores beats in a dual-port line RAM whose second
// read port feeds scanout independently.
//  clk_i, rst_ni                  clock, async active-low reset
//  host_a_valid/ready, host_a     TL A channel
//  host_d_valid/ready, host_d     TL D channel
//  host_b_valid, host_c_ready,
//  host_e_ready                   unused channels, tied off
//  rd_en_i, rd_addr_i, rd_data_o  scanout read port (1 cycle latency)
module display_controller_line_buffer
  import display_controller_line_buffer_pkg::*;
#(
  parameter int          DataWidth   = TlDataWidth,
  parameter int          AddrWidth   = TlAddrWidth,
  parameter int          SourceWidth = TlSourceWidth,
  parameter int          BlockSize   = 6,
  parameter int          Depth       = 512,
  parameter logic [63:0] BaseAddr    = 64'd0,
  localparam int         RamAw       = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 host_a_ready,
  input  logic                 host_a_valid,
  input  tl_a_t                host_a,
  input  logic                 host_d_ready,
  output logic                 host_d_valid,
  output tl_d_t                host_d,
  output logic                 host_b_valid,
  output logic                 host_c_ready,
  output logic                 host_e_ready,
  input  logic                 rd_en_i,
  input  logic [RamAw-1:0]     rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  localparam int NonBurstSize = $clog2(DataWidth / 8);
  localparam int CntW         = BlockSize - NonBurstSize + 1;
  localparam logic [AddrWidth-1:0] WinBytes = AddrWidth'(Depth) * AddrWidth'(DataWidth / 8);

  typedef enum logic [1:0] {Idle, PutBurst, Ack, GetResp} state_e;

  state_e                  r_state, w_state_nxt;
  logic [CntW-1:0]         r_cnt, r_last;
  logic [SourceWidth-1:0]  r_source;
  logic [TlSizeWidth-1:0]  r_size;
  logic                    r_denied, r_corrupt;
  logic [RamAw-1:0]        r_word;

  logic [AddrWidth-1:0]    w_off, w_span;
  logic                    w_denied, w_a_fire, w_d_fire;
  logic [RamAw-1:0]        w_word;
  logic [CntW-1:0]         w_last;
  logic                    w_ram_en, w_ram_we;
  logic [RamAw-1:0]        w_ram_addr;
  logic [DataWidth-1:0]    w_ram_q;
  logic                    w_unused;

  assign host_b_valid = 1'b0;
  assign host_c_ready = 1'b1;
  assign host_e_ready = 1'b1;
  assign w_unused     = ^host_a.param;

  // Request decode. An address below BaseAddr wraps w_off to a huge value,
  // so the single upper-bound check also rejects it.
  assign w_off    = host_a.address - AddrWidth'(BaseAddr);
  assign w_span   = AddrWidth'(1) << host_a.size;
  assign w_word   = w_off[NonBurstSize +: RamAw];
  assign w_last   = CntW'(tl_beats(32'(host_a.size), NonBurstSize) - 32'd1);
  assign w_denied = !(host_a.opcode inside {Get, PutFullData, PutPartialData})
                 || (host_a.size > TlSizeWidth'(BlockSize))
                 || ((host_a.address & (w_span - AddrWidth'(1))) != '0)
                 || (w_off >= WinBytes)
                 || ((w_off + w_span) > WinBytes);

  assign w_a_fire = host_a_valid && host_a_ready;
  assign w_d_fire = host_d_valid && host_d_ready;

  always_comb begin
    w_state_nxt  = r_state;
    host_a_ready = 1'b0;
    host_d_valid = 1'b0;
    host_d       = '0;
    w_ram_en     = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_addr   = r_word + RamAw'(r_cnt);
    case (r_state)
      Idle: begin
        host_a_ready = rst_ni;
        if (w_a_fire) begin
          w_ram_addr = w_word;
          if (host_a.opcode == Get) begin
            w_ram_en    = 1'b1;
            w_state_nxt = GetResp;
          end else begin
            w_ram_en    = !w_denied && !host_a.corrupt;
            w_ram_we    = w_ram_en;
            w_state_nxt = (w_last == '0) ? Ack : PutBurst;
          end
        end
      end
      PutBurst: begin
        host_a_ready = 1'b1;
        if (w_a_fire) begin
          w_ram_en = !r_denied && !r_corrupt && !host_a.corrupt;
          w_ram_we = w_ram_en;
          if (r_cnt == r_last) w_state_nxt = Ack;
        end
      end
      Ack: begin
        host_d_valid  = 1'b1;
        host_d.opcode = AccessAck;
        host_d.size   = r_size;
        host_d.source = r_source;
        host_d.denied = r_denied;
        if (host_d_ready) w_state_nxt = Idle;
      end
      GetResp: begin
        host_d_valid   = 1'b1;
        host_d.opcode  = AccessAckData;
        host_d.size    = r_size;
        host_d.source  = r_source;
        host_d.denied  = r_denied;
        host_d.corrupt = r_denied;
        host_d.data    = r_denied ? '0 : w_ram_q;
        // Next word is fetched only on a handshake so the RAM output holds under backpressure.
        if (host_d_ready) begin
          if (r_cnt == r_last) w_state_nxt = Idle;
          else begin
            w_ram_en   = 1'b1;
            w_ram_addr = r_word + RamAw'(r_cnt) + RamAw'(1);
          end
        end
      end
      default: w_state_nxt = Idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= Idle;
      r_cnt     <= '0;
      r_last    <= '0;
      r_source  <= '0;
      r_size    <= '0;
      r_denied  <= 1'b0;
      r_corrupt <= 1'b0;
      r_word    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        Idle: if (w_a_fire) begin
          r_source  <= host_a.source;
          r_size    <= host_a.size;
          r_denied  <= w_denied;
          r_corrupt <= host_a.corrupt;
          r_word    <= w_word;
          r_last    <= w_last;
          if (host_a.opcode != Get) r_cnt <= CntW'(1);
        end
        PutBurst: if (w_a_fire) begin
          r_cnt     <= r_cnt + CntW'(1);
          r_corrupt <= r_corrupt | host_a.corrupt;
        end
        GetResp: if (w_d_fire) r_cnt <= r_cnt + CntW'(1);
        default: ;
      endcase
      if (w_state_nxt == Idle) r_cnt <= '0;
    end
  end

  display_controller_line_ram #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_ram (
    .i_clk     (clk_i),
    .i_rst_n   (rst_ni),
    .i_a_en    (w_ram_en),
    .i_a_we    (w_ram_we),
    .i_a_be    (host_a.mask),
    .i_a_addr  (w_ram_addr),
    .i_a_wdata (host_a.data),
    .o_a_rdata (w_ram_q),
    .i_b_en    (rd_en_i),
    .i_b_addr  (rd_addr_i),
    .o_b_rdata (rd_data_o)
  );

endmodule

// File: tb/tb_display_controller_line_buffer.sv
// Directed bench for display_controller_line_buffer: Put/Get bursts, partial
// writes, denied requests, scanout read-first collision and mid-burst reset.
module tb_display_controller_line_buffer;
  import display_controller_line_buffer_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        host_a_ready, host_a_valid, host_d_ready, host_d_valid;
  logic        host_b_valid, host_c_ready, host_e_ready, rd_en_i;
  tl_a_t       host_a;
  tl_d_t       host_d;
  logic [8:0]  rd_addr_i;
  logic [63:0] rd_data_o;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  display_controller_line_buffer dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .host_a_ready (host_a_ready),
    .host_a_valid (host_a_valid),
    .host_a       (host_a),
    .host_d_ready (host_d_ready),
    .host_d_valid (host_d_valid),
    .host_d       (host_d),
    .host_b_valid (host_b_valid),
    .host_c_ready (host_c_ready),
    .host_e_ready (host_e_ready),
    .rd_en_i      (rd_en_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // All tasks start and end just after a rising edge.
  task automatic do_put(input tl_a_op_e op, input logic [2:0] size, input logic [63:0] addr,
                        input logic [7:0] mask, input int n, input logic [63:0] d0,
                        input logic src, input logic exp_den);
    for (int i = 0; i < n; i++) begin
      host_a         = '0;
      host_a.opcode  = op;
      host_a.size    = size;
      host_a.address = addr;
      host_a.mask    = mask;
      host_a.source  = src;
      host_a.data    = d0 + 64'(i);
      host_a_valid   = 1'b1;
      @(negedge clk_i);
      chk("put_ardy", host_a_ready, 1);
      @(posedge clk_i); #1;
    end
    host_a_valid = 1'b0;
    @(negedge clk_i);
    chk("ack_vld", host_d_valid, 1);
    chk("ack_op", host_d.opcode, AccessAck);
    chk("ack_src", host_d.source, src);
    chk("ack_size", host_d.size, size);
    chk("ack_den", host_d.denied, exp_den);
    chk("ack_cor", host_d.corrupt, 0);
    host_d_ready = 1'b1;
    @(posedge clk_i); #1;
    host_d_ready = 1'b0;
    @(negedge clk_i);
    chk("ack_done", host_d_valid, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic do_get(input logic [2:0] size, input logic [63:0] addr, input int n,
                        input logic [63:0] e0, input logic incr, input logic den,
                        input logic toggle, input logic src);
    int b = 0;
    int cyc = 0;
    logic [63:0] prev = '0;
    logic held = 1'b0;
    host_a         = '0;
    host_a.opcode  = Get;
    host_a.size    = size;
    host_a.address = addr;
    host_a.mask    = 8'hFF;
    host_a.source  = src;
    host_a_valid   = 1'b1;
    @(negedge clk_i);
    chk("get_ardy", host_a_ready, 1);
    @(posedge clk_i); #1;
    host_a_valid = 1'b0;
    while (b < n && cyc < 200) begin
      host_d_ready = (toggle && (cyc % 2 == 1)) ? 1'b0 : 1'b1;
      @(negedge clk_i);
      if (!host_d_valid) chk("get_dvld", host_d_valid, 1);
      else begin
        if (held) chk("get_hold", host_d.data, prev);
        chk("get_ardy_lo", host_a_ready, 0);
        if (host_d_ready) begin
          chk("get_data", host_d.data, den ? 64'd0 : (incr ? e0 + 64'(b) : e0));
          chk("get_op", host_d.opcode, AccessAckData);
          chk("get_den", host_d.denied, den);
          chk("get_cor", host_d.corrupt, den);
          chk("get_src", host_d.source, src);
          b++;
          held = 1'b0;
        end else begin
          prev = host_d.data;
          held = 1'b1;
        end
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    host_d_ready = 1'b0;
    if (b < n) chk("get_timeout", 64'(b), 64'(n));
    @(negedge clk_i);
    chk("get_idle", host_d_valid, 0);
    @(posedge clk_i); #1;
  endtask

  task automatic scan(input logic [8:0] a, input logic [63:0] exp);
    rd_en_i   = 1'b1;
    rd_addr_i = a;
    @(posedge clk_i); #1;
    rd_en_i = 1'b0;
    @(negedge clk_i);
    chk("scan", rd_data_o, exp);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    host_a       = '0;
    host_a_valid = 1'b0;
    host_d_ready = 1'b0;
    rd_en_i      = 1'b0;
    rd_addr_i    = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ardy", host_a_ready, 0);
    chk("rst_dvld", host_d_valid, 0);
    chk("rst_rd", rd_data_o, 0);
    chk("tie_b", host_b_valid, 0);
    chk("tie_c", host_c_ready, 1);
    chk("tie_e", host_e_ready, 1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 8-beat PutFullData at 0x40 (words 8..15), scanout readback
    do_put(PutFullData, 3'd6, 64'h40, 8'hFF, 8, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) scan(9'(8 + i), 64'(i));
    @(negedge clk_i);
    chk("scan_hold", rd_data_o, 64'd7);
    @(posedge clk_i); #1;

    // Get burst with d_ready 1010
    do_get(3'd6, 64'h40, 8, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Partial write over all-ones word 0
    do_put(PutFullData, 3'd3, 64'h0, 8'hFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    do_put(PutPartialData, 3'd3, 64'h0, 8'h0F, 1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b0);
    do_get(3'd3, 64'h0, 1, 64'hFFFF_FFFF_CCCC_DDDD, 1'b0, 1'b0, 1'b0, 1'b1);

    // Denied: oversize, misaligned, out of window (Get), plus an out-of-window Put
    do_get(3'd7, 64'h0, 16, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_get(3'd6, 64'h8, 8, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    do_get(3'd6, 64'h1000, 8, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_put(PutFullData, 3'd3, 64'h1000, 8'hFF, 1, 64'hDEAD, 1'b0, 1'b1);
    scan(9'd0, 64'hFFFF_FFFF_CCCC_DDDD);
    scan(9'd8, 64'd0);

    // Read-first collision at word 5
    do_put(PutFullData, 3'd3, 64'h28, 8'hFF, 1, 64'h9, 1'b0, 1'b0);
    host_a         = '0;
    host_a.opcode  = PutFullData;
    host_a.size    = 3'd3;
    host_a.address = 64'h28;
    host_a.mask    = 8'hFF;
    host_a.data    = 64'h1234;
    host_a_valid   = 1'b1;
    rd_en_i        = 1'b1;
    rd_addr_i      = 9'd5;
    @(posedge clk_i); #1;
    host_a_valid = 1'b0;
    rd_en_i      = 1'b0;
    @(negedge clk_i);
    chk("rf_old", rd_data_o, 64'h9);
    chk("rf_ack", host_d_valid, 1);
    host_d_ready = 1'b1;
    @(posedge clk_i); #1;
    host_d_ready = 1'b0;
    scan(9'd5, 64'h1234);

    // Reset after 4 beats of an 8-beat Put at 0x80 (words 16..23)
    for (int i = 0; i < 4; i++) begin
      host_a         = '0;
      host_a.opcode  = PutFullData;
      host_a.size    = 3'd6;
      host_a.address = 64'h80;
      host_a.mask    = 8'hFF;
      host_a.data    = 64'h100 + 64'(i);
      host_a_valid   = 1'b1;
      @(posedge clk_i); #1;
    end
    host_a_valid = 1'b0;
    rst_ni       = 1'b0;
    @(negedge clk_i);
    chk("mrst_ardy", host_a_ready, 0);
    chk("mrst_dvld", host_d_valid, 0);
    chk("mrst_rd", rd_data_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mrst_ardy1", host_a_ready, 1);
    repeat (3) @(negedge clk_i);
    chk("mrst_nod", host_d_valid, 0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 4; i++) scan(9'(16 + i), 64'h100 + 64'(i));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
